// File: rtl/vmem_seq_ctrl_pkg.sv
// Shared types and constants for the vector memory sequencer.
// Holds the FSM encoding and the packing rule for elements in a vector word.
package vmem_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam int unsigned ElemW = 32;

  // Element i of a packed vector occupies bits [i*elem_w +: elem_w].
  function automatic int unsigned elem_lsb(int unsigned idx, int unsigned elem_w);
    return idx * elem_w;
  endfunction

endpackage

// File: rtl/vmem_addr_gen.sv
// Element address/index generator: loads base and stride, then steps the
// address by the stride once per completed element.
module vmem_addr_gen #(
  parameter int unsigned NUM_ELEM = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [31:0]      base_i,
  input  logic [31:0]      stride_i,
  output logic [31:0]      addr_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [31:0]      addr_q;
  logic [31:0]      stride_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
    end else if (load_i) begin
      addr_q   <= base_i;
      stride_q <= stride_i;
      idx_q    <= '0;
    end else if (step_i) begin
      addr_q   <= addr_q + stride_q;
      idx_q    <= idx_q + 1'b1;
    end
  end

  assign addr_o = addr_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(NUM_ELEM - 1));

endmodule

// File: rtl/vmem_seq_ctrl.sv
// Splits one vector load/store from EX/MEM into NUM_ELEM scalar memory accesses,
// stalling upstream and gathering load elements into one write-back vector.
module vmem_seq_ctrl
  import vmem_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ELEM = 4,
  parameter int unsigned ELEM_W   = ElemW,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       vmem_valid_i,
  input  logic                       vmem_write_i,
  input  logic [31:0]                base_addr_i,
  input  logic [31:0]                stride_i,
  input  logic [4:0]                 vd_addr_i,
  input  logic [NUM_ELEM*ELEM_W-1:0] vstore_data_i,
  output logic                       stall_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [31:0]                mem_addr_o,
  output logic [ELEM_W-1:0]          mem_wdata_o,
  input  logic [ELEM_W-1:0]          mem_rdata_i,
  input  logic                       mem_ready_i,
  output logic                       vwb_valid_o,
  output logic [4:0]                 vwb_addr_o,
  output logic [NUM_ELEM*ELEM_W-1:0] vwb_data_o,
  output logic                       done_o
);

  state_e state_q, state_d;

  logic                       write_q;
  logic [4:0]                 vd_q;
  logic [NUM_ELEM*ELEM_W-1:0] store_q;
  logic [NUM_ELEM*ELEM_W-1:0] gather_q;

  logic             accept;
  logic             elem_done;
  logic [31:0]      addr;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign accept    = (state_q == StIdle) && vmem_valid_i;
  assign elem_done = (state_q == StAccess) && mem_ready_i;

  vmem_addr_gen #(
    .NUM_ELEM (NUM_ELEM),
    .IDX_W    (IDX_W)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .step_i   (elem_done && !last),
    .base_i   (base_addr_i),
    .stride_i (stride_i),
    .addr_o   (addr),
    .idx_o    (idx),
    .last_o   (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (vmem_valid_i) state_d = StAccess;
      StAccess: if (mem_ready_i && last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    vwb_valid_o = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: stall_o = vmem_valid_i;
      StAccess: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = write_q;
        mem_addr_o  = addr;
        mem_wdata_o = store_q[elem_lsb(32'(idx), ELEM_W) +: ELEM_W];
      end
      StDone: begin
        done_o      = 1'b1;
        vwb_valid_o = !write_q;
      end
      default: ;
    endcase
  end

  // Operands are captured only at accept, so EX/MEM may change freely afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q  <= 1'b0;
      vd_q     <= '0;
      store_q  <= '0;
      gather_q <= '0;
    end else begin
      if (accept) begin
        write_q <= vmem_write_i;
        vd_q    <= vd_addr_i;
        store_q <= vstore_data_i;
      end
      if (elem_done && !write_q) begin
        gather_q[elem_lsb(32'(idx), ELEM_W) +: ELEM_W] <= mem_rdata_i;
      end
    end
  end

  assign vwb_addr_o = vd_q;
  assign vwb_data_o = gather_q;

endmodule

// File: tb/tb_vmem_seq_ctrl.sv
// Self-checking bench for vmem_seq_ctrl: directed scenarios plus randomized ops
// compared against an arithmetic model (address_i = base + i*stride).
module tb_vmem_seq_ctrl;

  localparam int NE = 4;
  localparam int EW = 32;
  localparam int VW = NE * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          vmem_valid, vmem_write;
  logic [31:0]   base_addr, stride;
  logic [4:0]    vd_addr;
  logic [VW-1:0] vstore_data;
  logic          stall, mem_req, mem_we, mem_ready;
  logic [31:0]   mem_addr;
  logic [EW-1:0] mem_wdata, mem_rdata;
  logic          vwb_valid, done;
  logic [4:0]    vwb_addr;
  logic [VW-1:0] vwb_data;

  vmem_seq_ctrl #(.NUM_ELEM(NE), .ELEM_W(EW), .IDX_W(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .vmem_valid_i  (vmem_valid),
    .vmem_write_i  (vmem_write),
    .base_addr_i   (base_addr),
    .stride_i      (stride),
    .vd_addr_i     (vd_addr),
    .vstore_data_i (vstore_data),
    .stall_o       (stall),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_ready_i   (mem_ready),
    .vwb_valid_o   (vwb_valid),
    .vwb_addr_o    (vwb_addr),
    .vwb_data_o    (vwb_data),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Memory model: read data is a fixed function of the address.
  assign mem_rdata = mem_addr ^ 32'hA5;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]   obs_addr[$];
  logic [31:0]   obs_wdata[$];
  logic          obs_we[$];
  int            obs_latency, obs_stall, obs_unstable, obs_vwb_cnt, obs_done_cnt, obs_overlap;
  logic [VW-1:0] obs_vwb_data;
  logic [4:0]    obs_vwb_addr;

  function automatic logic [31:0] ref_addr(logic [31:0] b, logic [31:0] s, int i);
    return b + s * 32'(i);
  endfunction

  function automatic logic [VW-1:0] ref_load_vec(logic [31:0] b, logic [31:0] s);
    logic [VW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*EW +: EW] = ref_addr(b, s, i) ^ 32'hA5;
    return v;
  endfunction

  // Drives one op from IDLE and records what the DUT does on the memory port.
  // mode 0: ready tied high; 1: ready low 3 cycles on element 2; 2: random ready.
  task automatic run_op(input logic wr, input logic [31:0] b, input logic [31:0] s,
                        input logic [4:0] vd, input logic [VW-1:0] sd, input int mode);
    int k = 0;
    int waited = 0;
    int n = 0;
    logic rdy;
    logic prev_req = 1'b0, prev_rdy = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    obs_addr.delete(); obs_wdata.delete(); obs_we.delete();
    obs_latency = -1; obs_stall = 0; obs_unstable = 0;
    obs_vwb_cnt = 0; obs_done_cnt = 0; obs_overlap = 0;
    @(negedge clk);
    vmem_valid = 1'b1; vmem_write = wr; base_addr = b; stride = s;
    vd_addr = vd; vstore_data = sd; mem_ready = 1'b0;
    #1;
    if (stall) obs_stall++;
    while (n < 200) begin
      @(negedge clk);
      n++;
      vmem_valid  = 1'b0;
      base_addr   = $urandom; stride = $urandom; vd_addr = 5'($urandom);
      vmem_write  = 1'($urandom);
      vstore_data = {$urandom, $urandom, $urandom, $urandom};
      rdy = 1'b0;
      if (mem_req) begin
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) begin
          if (k == 2 && waited < 3) waited++;
          else rdy = 1'b1;
        end else rdy = ($urandom_range(0, 2) != 0);
      end
      mem_ready = rdy;
      if (stall) obs_stall++;
      if (done && stall) obs_overlap++;
      if (prev_req && !prev_rdy &&
          (!mem_req || mem_addr !== prev_addr || mem_wdata !== prev_wdata)) obs_unstable++;
      if (mem_req && rdy) begin
        obs_addr.push_back(mem_addr);
        obs_we.push_back(mem_we);
        obs_wdata.push_back(mem_wdata);
        k++;
      end
      if (vwb_valid) obs_vwb_cnt++;
      if (done) begin
        obs_done_cnt++;
        obs_latency  = n;
        obs_vwb_data = vwb_data;
        obs_vwb_addr = vwb_addr;
        break;
      end
      prev_req = mem_req; prev_rdy = rdy; prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vmem_valid = 1'b0; vmem_write = 1'b0; base_addr = '0; stride = '0;
    vd_addr = '0; vstore_data = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, stall, done, vwb_valid} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, stall, done, vwb_valid});
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || vwb_addr !== '0 || vwb_data !== '0)
      $display("FAIL reset_data: got addr=%h wdata=%h vwb_addr=%h vwb_data=%h want all 0",
               mem_addr, mem_wdata, vwb_addr, vwb_data);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] exp_a[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run_op(1'b0, 32'h100, 32'd4, 5'd7, '0, 0);
    n_checks++;
    if (obs_latency !== 5) $display("FAIL load_latency: got %0d want 5", obs_latency);
    else n_pass++;
    n_checks++;
    if (obs_stall !== 5) $display("FAIL load_stall: got %0d want 5", obs_stall);
    else n_pass++;
    n_checks++;
    if (obs_addr.size() !== NE) $display("FAIL load_count: got %0d want %0d", obs_addr.size(), NE);
    else n_pass++;
    for (int i = 0; i < obs_addr.size() && i < NE; i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_a[i] || obs_we[i] !== 1'b0)
        $display("FAIL load_addr[%0d]: got %h we=%b want %h we=0", i, obs_addr[i], obs_we[i],
                 exp_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_vwb_data !== 128'h000001A9_000001AD_000001A1_000001A5)
      $display("FAIL load_data: got %h want 000001a9000001ad000001a1000001a5", obs_vwb_data);
    else n_pass++;
    n_checks++;
    if (obs_vwb_cnt !== 1 || obs_vwb_addr !== 5'd7 || obs_done_cnt !== 1)
      $display("FAIL load_wb: got vwb=%0d vd=%0d done=%0d want 1 7 1", obs_vwb_cnt, obs_vwb_addr,
               obs_done_cnt);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [31:0] exp_a[4] = '{32'h200, 32'h1F8, 32'h1F0, 32'h1E8};
    run_op(1'b1, 32'h200, 32'hFFFF_FFF8, 5'd3, {32'd4, 32'd3, 32'd2, 32'd1}, 0);
    n_checks++;
    if (obs_addr.size() !== NE) $display("FAIL store_count: got %0d want %0d", obs_addr.size(), NE);
    else n_pass++;
    for (int i = 0; i < obs_addr.size() && i < NE; i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_a[i] || obs_wdata[i] !== 32'(i + 1) || obs_we[i] !== 1'b1)
        $display("FAIL store_elem[%0d]: got %h@%h we=%b want %h@%h we=1", i, obs_wdata[i],
                 obs_addr[i], obs_we[i], 32'(i + 1), exp_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_done_cnt !== 1 || obs_vwb_cnt !== 0 || obs_latency !== 5)
      $display("FAIL store_done: got done=%0d vwb=%0d lat=%0d want 1 0 5", obs_done_cnt,
               obs_vwb_cnt, obs_latency);
    else n_pass++;
  endtask

  task automatic test_ready_gap();
    run_op(1'b0, 32'h340, 32'h10, 5'd9, '0, 1);
    n_checks++;
    if (obs_latency !== 8) $display("FAIL gap_latency: got %0d want 8", obs_latency);
    else n_pass++;
    n_checks++;
    if (obs_unstable !== 0) $display("FAIL gap_hold: got %0d changes want 0", obs_unstable);
    else n_pass++;
    n_checks++;
    if (obs_stall !== 8) $display("FAIL gap_stall: got %0d want 8", obs_stall);
    else n_pass++;
    n_checks++;
    if (obs_vwb_data !== ref_load_vec(32'h340, 32'h10))
      $display("FAIL gap_data: got %h want %h", obs_vwb_data, ref_load_vec(32'h340, 32'h10));
    else n_pass++;
  endtask

  task automatic test_wrap();
    run_op(1'b0, 32'hFFFF_FFFC, 32'd4, 5'd12, '0, 0);
    n_checks++;
    if (obs_addr.size() !== NE || obs_addr[1] !== 32'h0 || obs_addr[3] !== 32'h8)
      $display("FAIL wrap_addr: got n=%0d a1=%h a3=%h want 4 00000000 00000008",
               obs_addr.size(), obs_addr[1], obs_addr[3]);
    else n_pass++;
    n_checks++;
    if (obs_vwb_data !== ref_load_vec(32'hFFFF_FFFC, 32'd4))
      $display("FAIL wrap_data: got %h want %h", obs_vwb_data,
               ref_load_vec(32'hFFFF_FFFC, 32'd4));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    vmem_valid = 1'b1; vmem_write = 1'b0; base_addr = 32'h500; stride = 32'd4; vd_addr = 5'd5;
    @(negedge clk);
    vmem_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h504)
      $display("FAIL rstmid_setup: got req=%b addr=%h want 1 00000504", mem_req, mem_addr);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || vwb_valid !== 1'b0)
      $display("FAIL rstmid_drop: got req=%b stall=%b done=%b vwb=%b want 0 0 0 0", mem_req,
               stall, done, vwb_valid);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (vwb_valid || done) pulses++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (vwb_valid || done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL rstmid_nowb: got %0d pulses want 0", pulses);
    else n_pass++;
    run_op(1'b0, 32'h600, 32'd8, 5'd6, '0, 0);
    n_checks++;
    if (obs_addr.size() !== NE || obs_addr[0] !== 32'h600 || obs_latency !== 5)
      $display("FAIL rstmid_next: got n=%0d a0=%h lat=%0d want 4 00000600 5", obs_addr.size(),
               obs_addr[0], obs_latency);
    else n_pass++;
    n_checks++;
    if (obs_vwb_data !== ref_load_vec(32'h600, 32'd8) || obs_vwb_cnt !== 1)
      $display("FAIL rstmid_data: got %h cnt=%0d want %h cnt=1", obs_vwb_data, obs_vwb_cnt,
               ref_load_vec(32'h600, 32'd8));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n = 0, d1 = -1, d2 = -1, overlap = 0;
    logic idle_ok = 1'b0;
    logic [31:0] first_b = '0;
    logic [VW-1:0] data_b = '0;
    @(negedge clk);
    vmem_valid = 1'b1; vmem_write = 1'b0; base_addr = 32'h700; stride = 32'd4;
    vd_addr = 5'd1; mem_ready = 1'b1;
    while (d2 < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (done && stall) overlap++;
      if (d1 > 0 && n == d1 + 1) idle_ok = stall && !mem_req && !done;
      if (d1 > 0 && n == d1 + 2) begin
        first_b = mem_addr;
        vmem_valid = 1'b0;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = n;
          base_addr = 32'h800; stride = 32'h20; vd_addr = 5'd2;
        end else begin
          d2 = n;
          data_b = vwb_data;
        end
      end
    end
    vmem_valid = 1'b0; mem_ready = 1'b0;
    n_checks++;
    if (d1 !== 5 || d2 !== 11)
      $display("FAIL b2b_timing: got done at %0d,%0d want 5,11", d1, d2);
    else n_pass++;
    n_checks++;
    if (idle_ok !== 1'b1 || overlap !== 0)
      $display("FAIL b2b_accept: got idle_ok=%b overlap=%0d want 1 0", idle_ok, overlap);
    else n_pass++;
    n_checks++;
    if (first_b !== 32'h800 || data_b !== ref_load_vec(32'h800, 32'h20))
      $display("FAIL b2b_second: got a0=%h data=%h want 00000800 %h", first_b, data_b,
               ref_load_vec(32'h800, 32'h20));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      logic          wr = 1'($urandom_range(0, 1));
      logic [31:0]   b  = $urandom;
      logic [31:0]   s  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      logic [4:0]    vd = 5'($urandom);
      logic [VW-1:0] sd = {$urandom, $urandom, $urandom, $urandom};
      int            bad = 0;
      run_op(wr, b, s, vd, sd, 2);
      n_checks++;
      if (obs_done_cnt !== 1 || obs_addr.size() !== NE || obs_unstable !== 0 ||
          obs_stall !== obs_latency || obs_overlap !== 0)
        $display("FAIL rand_ctrl[%0d]: got done=%0d n=%0d unst=%0d stall=%0d lat=%0d ov=%0d",
                 t, obs_done_cnt, obs_addr.size(), obs_unstable, obs_stall, obs_latency,
                 obs_overlap);
      else n_pass++;
      for (int i = 0; i < obs_addr.size() && i < NE; i++) begin
        if (obs_addr[i] !== ref_addr(b, s, i) || obs_we[i] !== wr) bad++;
        if (wr && obs_wdata[i] !== sd[i*EW +: EW]) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL rand_elems[%0d]: got %0d bad elements want 0", t, bad);
      else n_pass++;
      n_checks++;
      if (wr ? (obs_vwb_cnt !== 0)
             : (obs_vwb_cnt !== 1 || obs_vwb_addr !== vd || obs_vwb_data !== ref_load_vec(b, s)))
        $display("FAIL rand_wb[%0d]: got vwb=%0d vd=%0d data=%h want wr=%b vd=%0d data=%h", t,
                 obs_vwb_cnt, obs_vwb_addr, obs_vwb_data, wr, vd, ref_load_vec(b, s));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_ready_gap();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
